// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared constants and helpers for the rate-1/2, K=7 hard-decision Viterbi
// decoder (generators 133/171 octal).
//   K, NUM_STATES   : code constraint length and trellis size
//   G0, G1          : generator taps over {x, s5, s4, s3, s2, s1, s0}
//   state_e         : decoder control FSM encoding
//   init_metric()   : starting metric of every state except state 0
//   expected_pair() : coded pair produced when input x leaves state s
// -----------------------------------------------------------------------------
package viterbi_pkg;

  localparam int K          = 7;
  localparam int NUM_STATES = 64;

  // Tap vectors are ordered {x, s5, s4, s3, s2, s1, s0}.
  // G0 drives y[1] (x^s4^s3^s1^s0) and G1 drives y[0] (x^s5^s4^s3^s0).
  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Non-zero states start a quarter of the metric range behind state 0, so
  // the encoder's known all-zero start state wins early decisions.
  function automatic int init_metric(input int metric_w);
    return 1 << (metric_w - 2);
  endfunction

  function automatic logic [1:0] expected_pair(input logic [5:0] state,
                                               input logic       x);
    logic [K-1:0] taps;
    taps = {x, state};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/viterbi_decoder_acs.sv
// -----------------------------------------------------------------------------
// acs_unit
// Add-compare-select for one trellis state.
//   pm0, pm1 : path metrics of the predecessors with LSB 0 and LSB 1
//   bm0, bm1 : branch metrics (0..2) for the transitions from those states
//   pm_new   : surviving metric
//   sel      : 1 when the LSB-1 predecessor survives (ties pick LSB 0)
// -----------------------------------------------------------------------------
module acs_unit #(
  parameter int METRIC_W = 8
) (
  input  logic [METRIC_W-1:0] pm0,
  input  logic [METRIC_W-1:0] pm1,
  input  logic [1:0]          bm0,
  input  logic [1:0]          bm1,
  output logic [METRIC_W-1:0] pm_new,
  output logic                sel
);

  logic [METRIC_W-1:0] cand0;
  logic [METRIC_W-1:0] cand1;
  logic [METRIC_W-1:0] diff;

  // Metrics wrap freely; the metric spread stays below half the range, so the
  // sign of the modular difference orders the candidates correctly.
  always_comb begin
    cand0  = pm0 + METRIC_W'(bm0);
    cand1  = pm1 + METRIC_W'(bm1);
    diff   = cand1 - cand0;
    sel    = diff[METRIC_W-1];
    pm_new = sel ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// -----------------------------------------------------------------------------
// viterbi_decoder
// Hard-decision Viterbi decoder, rate 1/2, K=7, register-exchange survivors.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   y[1:0]    : received coded pair, taken when run && ready
//   run       : pair valid
//   last      : with run, final pair of the frame (tail included)
//   ready     : low while the frame-end survivor is being flushed
//   x_decoded : decoded bit
//   valid     : x_decoded valid
//   x_last    : with valid, final decoded bit of the frame
// During a frame a bit is released once the survivors are TB_DEPTH deep; at
// frame end the state-0 survivor (tail forces state 0) is emitted oldest first.
// -----------------------------------------------------------------------------
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 32,
  parameter int METRIC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] y,
  input  logic       run,
  input  logic       last,
  output logic       ready,
  output logic       x_decoded,
  output logic       valid,
  output logic       x_last
);

  localparam int FILL_W = $clog2(TB_DEPTH + 1);
  localparam int IDX_W  = $clog2(TB_DEPTH);
  localparam logic [METRIC_W-1:0] INIT_METRIC = METRIC_W'(init_metric(METRIC_W));

  state_e state_q, state_d;
  logic   accept;
  logic   frame_done;

  logic [METRIC_W-1:0] pm_q     [NUM_STATES];
  logic [METRIC_W-1:0] pm_new   [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_q   [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_new [NUM_STATES];
  logic [NUM_STATES-1:0] sel;

  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_inc;
  logic              fill_full;
  logic [IDX_W-1:0]  flush_idx_q;

  assign fill_full = (fill_q == FILL_W'(TB_DEPTH));
  assign fill_inc  = fill_full ? fill_q : fill_q + FILL_W'(1);
  assign ready     = (state_q != FLUSH);

  // ---------------------------------------------------------------------------
  // Trellis: state n = {x, s[5:1]}, predecessors {n[4:0], b}, decoded bit n[5].
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < NUM_STATES; n++) begin : g_state
    localparam logic [5:0] NS = 6'(n);
    localparam logic [5:0] P0 = {NS[4:0], 1'b0};
    localparam logic [5:0] P1 = {NS[4:0], 1'b1};
    localparam logic [1:0] E0 = expected_pair(P0, NS[5]);
    localparam logic [1:0] E1 = expected_pair(P1, NS[5]);

    logic [1:0] d0, d1, bm0, bm1;

    assign d0  = y ^ E0;
    assign d1  = y ^ E1;
    assign bm0 = {1'b0, d0[1]} + {1'b0, d0[0]};
    assign bm1 = {1'b0, d1[1]} + {1'b0, d1[0]};

    acs_unit #(.METRIC_W(METRIC_W)) u_acs (
      .pm0    (pm_q[P0]),
      .pm1    (pm_q[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_new (pm_new[n]),
      .sel    (sel[n])
    );

    assign surv_new[n] = {(sel[n] ? surv_q[P1][TB_DEPTH-2:0]
                                  : surv_q[P0][TB_DEPTH-2:0]), NS[5]};
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch forms.
    state_d    = state_q;
    accept     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        accept = run;
        if (run) state_d = last ? FLUSH : RUN;
      end
      FLUSH: begin
        if (flush_idx_q == '0) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Metrics, survivors, fill count and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      flush_idx_q <= '0;
      x_decoded   <= 1'b0;
      valid       <= 1'b0;
      x_last      <= 1'b0;
      // NOTE: survivors are flops (not RAM), so clearing them on reset is legal
      // and keeps a reset mid-frame from leaking stale history.
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : INIT_METRIC;
        surv_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout, so every state sees pre-edge metrics.
      state_q <= state_d;
      valid   <= 1'b0;
      x_last  <= 1'b0;

      if (accept) begin
        for (int i = 0; i < NUM_STATES; i++) begin
          pm_q[i]   <= pm_new[i];
          surv_q[i] <= surv_new[i];
        end
        fill_q <= fill_inc;
        // Oldest bit of the pre-update state-0 survivor: pair k-TB_DEPTH.
        if (fill_full) begin
          x_decoded <= surv_q[0][TB_DEPTH-1];
          valid     <= 1'b1;
        end
        if (last) flush_idx_q <= IDX_W'(fill_inc - FILL_W'(1));
      end

      if (state_q == FLUSH) begin
        x_decoded   <= surv_q[0][flush_idx_q];
        valid       <= 1'b1;
        x_last      <= (flush_idx_q == '0);
        flush_idx_q <= flush_idx_q - IDX_W'(1);
      end

      // Next frame starts from the known all-zero encoder state.
      if (frame_done) begin
        fill_q <= '0;
        for (int i = 0; i < NUM_STATES; i++) begin
          pm_q[i] <= (i == 0) ? '0 : INIT_METRIC;
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// -----------------------------------------------------------------------------
// tb_viterbi_decoder
// Directed bench for viterbi_decoder (TB_DEPTH=32, METRIC_W=8): impulse,
// all-zero frame latency, noisy loopback, idle gaps, back-to-back frames,
// run during flush, single-pair frame and reset during flush.
// -----------------------------------------------------------------------------
module tb_viterbi_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] y   = 2'b00;
  logic       run = 1'b0;
  logic       last = 1'b0;
  logic       ready, x_decoded, valid, x_last;

  viterbi_decoder #(.TB_DEPTH(32), .METRIC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .y         (y),
    .run       (run),
    .last      (last),
    .ready     (ready),
    .x_decoded (x_decoded),
    .valid     (valid),
    .x_last    (x_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  bit out_bits[$];
  bit out_last[$];
  int out_acc[$];
  int acc_cnt     = 0;
  int ready_low   = 0;
  int frames_done = 0;

  always @(posedge clk) if (rst && run && ready) acc_cnt++;

  always @(negedge clk) begin
    if (rst) begin
      if (valid) begin
        out_bits.push_back(x_decoded);
        out_last.push_back(x_last);
        out_acc.push_back(acc_cnt);
        if (x_last) frames_done++;
      end
      if (!ready) ready_low++;
    end
  end

  task automatic clear_mon();
    out_bits.delete();
    out_last.delete();
    out_acc.delete();
    acc_cnt     = 0;
    ready_low   = 0;
    frames_done = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic send_frame(input logic [1:0] ys[$], input int max_gap);
    for (int i = 0; i < ys.size(); i++) begin
      int guard = 0;
      while (!ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!ready) check("ready_wait", 32'(ready), 32'd1);
      y    = ys[i];
      run  = 1'b1;
      last = (i == ys.size() - 1);
      @(posedge clk); #1;
      run  = 1'b0;
      last = 1'b0;
      repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_frame(input string tag);
    int cyc = 0;
    while (frames_done == 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (frames_done == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_bits(input string tag, input bit exp[$]);
    int errs = 0, lasts = 0, lastpos = -1;
    check({tag, "_count"}, 32'(out_bits.size()), 32'(exp.size()));
    for (int i = 0; i < out_bits.size() && i < exp.size(); i++)
      if (out_bits[i] != exp[i]) errs++;
    for (int i = 0; i < out_last.size(); i++)
      if (out_last[i]) begin
        lasts++;
        lastpos = i;
      end
    check({tag, "_bit_errors"}, 32'(errs), 32'd0);
    check({tag, "_x_last_count"}, 32'(lasts), 32'd1);
    check({tag, "_x_last_pos"}, 32'(lastpos), 32'(exp.size() - 1));
  endtask

  // Reference encoder: y[1]=x^s4^s3^s1^s0, y[0]=x^s5^s4^s3^s0, s'={x,s[5:1]}.
  function automatic logic [1:0] enc(input logic [5:0] s, input logic x);
    return {x ^ s[4] ^ s[3] ^ s[1] ^ s[0], x ^ s[5] ^ s[4] ^ s[3] ^ s[0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [1:0] imp_y[$];
  bit         imp_x[$];
  logic [1:0] zero_y[$];
  bit         zero_x[$];
  logic [1:0] lb_y[$];
  bit         lb_x[$];
  bit         first_out[$];
  logic [1:0] one_y[$];
  bit         one_x[$];

  initial begin
    logic [5:0] s;
    logic [6:0] prbs;
    logic       xb;
    logic [1:0] p;

    imp_y = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
    imp_x = '{1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 48; i++) begin
      zero_y.push_back(2'b00);
      zero_x.push_back(1'b0);
    end
    one_y = '{2'b00};
    one_x = '{0};

    // 200 PRBS7 bits + 6 tail zeros, one channel bit flipped every 10 pairs.
    s    = '0;
    prbs = 7'h5A;
    for (int i = 0; i < 206; i++) begin
      if (i < 200) begin
        xb   = prbs[6] ^ prbs[5];
        prbs = {prbs[5:0], xb};
      end else begin
        xb = 1'b0;
      end
      p = enc(s, xb);
      s = {xb, s[5:1]};
      if (i % 10 == 9) p = p ^ ((i % 20 == 9) ? 2'b10 : 2'b01);
      lb_y.push_back(p);
      lb_x.push_back(xb);
    end

    // Reset values.
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_x_last", 32'(x_last), 32'd0);
    check("rst_x_decoded", 32'(x_decoded), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Impulse response.
    clear_mon();
    send_frame(imp_y, 0);
    wait_frame("impulse");
    check_bits("impulse", imp_x);
    check("impulse_ready_low", 32'(ready_low), 32'd7);
    if (out_acc.size() > 0) check("impulse_first_valid_acc", 32'(out_acc[0]), 32'd7);

    // All-zero 48-pair frame: first bit after the 33rd accept.
    clear_mon();
    send_frame(zero_y, 0);
    wait_frame("zero48");
    check_bits("zero48", zero_x);
    if (out_acc.size() >= 17) begin
      check("zero48_first_valid_acc", 32'(out_acc[0]), 32'd33);
      check("zero48_16th_valid_acc", 32'(out_acc[15]), 32'd48);
    end
    check("zero48_ready_low", 32'(ready_low), 32'd32);

    // Noisy loopback, no gaps.
    clear_mon();
    send_frame(lb_y, 0);
    wait_frame("loopback");
    check_bits("loopback", lb_x);

    // Same frame with random idle gaps, then back-to-back repeat.
    clear_mon();
    send_frame(lb_y, 3);
    wait_frame("gaps");
    check_bits("gaps", lb_x);
    first_out = out_bits;
    clear_mon();
    send_frame(lb_y, 0);
    wait_frame("second");
    check_bits("second", lb_x);
    check("second_matches_first", 32'(out_bits == first_out), 32'd1);

    // run held high during flush must be ignored.
    clear_mon();
    send_frame(imp_y, 0);
    run  = 1'b1;
    last = 1'b1;
    y    = 2'b11;
    repeat (5) begin
      @(posedge clk); #1;
    end
    run  = 1'b0;
    last = 1'b0;
    wait_frame("flush_run");
    check_bits("flush_run", imp_x);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("flush_run_no_extra", 32'(out_bits.size()), 32'd7);

    // Single-pair frame.
    clear_mon();
    send_frame(one_y, 0);
    wait_frame("n1");
    check_bits("n1", one_x);
    check("n1_ready_low", 32'(ready_low), 32'd1);

    // Reset in the middle of a 40-pair flush.
    clear_mon();
    zero_y = zero_y[0:39];
    send_frame(zero_y, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("midflush_valid_before", 32'(valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midflush_valid", 32'(valid), 32'd0);
    check("midflush_x_last", 32'(x_last), 32'd0);
    check("midflush_ready", 32'(ready), 32'd1);
    check("midflush_no_frame_end", 32'(frames_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_mon();
    send_frame(imp_y, 0);
    wait_frame("post_reset");
    check_bits("post_reset", imp_x);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
Hard-decision Viterbi decoder for the 802.11a rate-1/2, K=7 convolutional code (g0=133 octal, g1=171 octal). It is the receive-side counterpart of the transmit convolutional encoder.
- Consumes one coded bit pair per `run` cycle.
- Keeps 64 path metrics and register-exchange survivors.
- Emits decoded bits with fixed latency during the frame, then flushes the survivor of state 0 at frame end. Tail bits force the encoder back to state 0.

Parameters:
TB_DEPTH, 32, survivor length in bits (traceback depth); legal range 8..64
METRIC_W, 8, path metric width; compared modulo 2^METRIC_W

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
y  input  2  coded pair; y[1] = x^s4^s3^s1^s0, y[0] = x^s5^s4^s3^s0
run  input  1  y valid this cycle; ignored while ready=0
last  input  1  qualifies run: final pair of frame (tail included)
ready  output  1  decoder accepts run; low during flush
x_decoded  output  1  decoded bit
valid  output  1  x_decoded valid this cycle
x_last  output  1  with valid: final decoded bit of frame

Behaviour:
- Reset: all outputs 0 except ready=1. Metrics are at initial values, survivors are 0, fill count is 0, FSM is in IDLE.
- State numbering: encoder shift register {s5..s0}, where s5 is the newest input bit. Next state n = {x, s[5:1]}. The predecessors of n are {n[4:0],0} and {n[4:0],1}, and the decoded bit for n is n[5].
- Branch metric: Hamming distance between y and the expected pair for (predecessor, n[5]); range 0..2.
- ACS, per accepted pair, for all 64 states in parallel:
  - PM'[n] = min of PM[p]+BM over both predecessors.
  - Comparison uses the sign of the METRIC_W-bit modulo difference.
  - Tie selects the predecessor with LSB 0.
  - SURV'[n] = {SURV[p][TB_DEPTH-2:0], n[5]}.
- Frame start: the first accepted pair after IDLE uses initial metrics: PM[0]=0, all others 2^(METRIC_W-2).
- FSM states IDLE, RUN, FLUSH:
  - IDLE -> RUN on an accepted run with last=0.
  - IDLE or RUN -> FLUSH on an accepted run with last=1.
  - FLUSH -> IDLE after the final flush bit.
- Fill count increments per accepted pair and saturates at TB_DEPTH.
- Steady-state output:
  - On an accepted pair when fill==TB_DEPTH (before increment), the block registers x_decoded = SURV[0][TB_DEPTH-1] (pre-update) and valid=1.
  - These appear the cycle after the accepting edge.
  - This output decodes pair k-TB_DEPTH.
- Flush (ready=0, run ignored):
  - Emits min(N, TB_DEPTH) bits from the post-update SURV[0], oldest first (index fill-1 down to 0), one per cycle.
  - x_last=1 accompanies the final bit.
  - The next cycle returns to IDLE with ready=1, and metrics and fill are re-initialised.
- Totals: the number of decoded bits always equals the number of accepted pairs N. N=1 is legal: one flush bit with x_last.
- Idle gaps: run=0 in RUN holds all state, and valid=0.
- Reset mid-frame or mid-flush: immediate return to reset values. A partial frame is discarded with no x_last.
- Metric arithmetic: no normalisation. Modulo compare is safe because the spread is at most 2*(K-1)+2^(METRIC_W-2) < 2^(METRIC_W-1).

Decomposition:
- Package viterbi_pkg: K=7, NUM_STATES=64, G0=7'o133, G1=7'o171, INIT_METRIC, FSM state encoding, function expected_pair(state, bit).
- Sub-module acs_unit (one per state, instantiated 64 times via generate):
  - Inputs: two predecessor metrics, two branch metrics.
  - Outputs: new metric and select bit.
  - Survivor exchange and the FSM stay in the top level.

Test Plan:
- Impulse: pairs y = 11,01,11,11,00,10,11 (last on 7th) -> after 7 accepts, ready=0 for 7 cycles; outputs 1,0,0,0,0,0,0 with x_last on the 7th; valid never high before flush.
- All-zero frame, N=48, y=00 -> first valid the cycle after the 33rd accept; 16 zeros during RUN, then 32 flush zeros; x_last on the 48th.
- Loopback with the team encoder, 200 PRBS bits plus 6 zero tail bits, one y bit flipped every 10 pairs -> all 206 decoded bits match the input, including the tail zeros.
- run gaps (random 0-3 idle cycles), then a second frame back-to-back after IDLE -> identical output; second frame starts from initial metrics.
- run asserted during FLUSH -> ignored, pair count unchanged; last with N=1, y=00 -> single bit 0 with x_last.
- rst pulled low mid-flush of a 40-pair frame -> valid/x_last drop to 0 and ready=1 immediately; the following 7-pair impulse frame decodes correctly.
